pool_stream: RTL and testbench
==============================

Name: pool_stream

Overview:
- Parametrised streaming 2x2/stride-2 max-pool engine; successor to the fixed 18-channel, 24x24, flat-bus pooling layer.
- Consumes one raster-ordered input pixel per accepted beat, carrying all channels in parallel.
- Emits one pooled pixel per 2x2 window, using a half-width line buffer instead of full-frame flat buses.
- Sits between a conv layer's streaming output and the next conv/FC stage, with valid/ready on both sides.

Parameters:
- CHANNELS, 18, channels carried per beat.
- DATA_W, 1, bits per channel value (1 = binarised activations).
- IMG_W, 24, input frame width in pixels; even, >= 2.
- IMG_H, 24, input frame height in pixels; even, >= 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  CHANNELS*DATA_W  one pixel; channel c at bits [c*DATA_W +: DATA_W].
- in_last  in  1  marks the final pixel of a frame.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accept.
- out_data  out  CHANNELS*DATA_W  pooled pixel, same channel packing as in_data.
- out_last  out  1  marks the final pooled pixel of a frame, (IMG_W/2)*(IMG_H/2)-th output.
- frame_err  out  1  one-cycle pulse on in_last/position mismatch.

Behaviour:
- Reset values: in_ready 0 while rst is high; out_valid 0, out_data 0, out_last 0, frame_err 0. Counters col=0, row=0, hold register 0. Line buffer is not reset; every entry is written before it is read.
- in_ready = !out_valid || out_ready. A single output register is used; a simultaneous drain and refill produces no bubble.
- Beat handling, on acceptance. max() is per channel, unsigned compare.
  - Even row, even col: hold <= pixel.
  - Even row, odd col: lbuf[col/2] <= max(hold, pixel).
  - Odd row, even col: hold <= max(lbuf[col/2], pixel).
  - Odd row, odd col: out_data <= max(hold, pixel); out_valid <= 1; out_last <= (row==IMG_H-1 && col==IMG_W-1).
- Latency: out_valid rises the cycle after the window's bottom-right pixel is accepted.
- Output handshake: out_valid falls after out_valid && out_ready unless a new window completes in the same cycle.
- Counters: col wraps IMG_W-1 -> 0 and increments row. row wraps IMG_H-1 -> 0 (frame end).
- Frame sync:
  - in_last with the final position: normal end, no error.
  - in_last at any other position: frame_err pulses; col and row are forced to 0 after that beat; the partial window is discarded and no output is produced for it.
  - Final position without in_last: frame_err pulses; counters wrap normally.
- Reset mid-frame: all state is cleared immediately; any pending output is dropped. The next accepted beat is treated as pixel (0,0).
- A held output keeps out_data and out_last stable while out_valid && !out_ready.

Optional Feature:
- POOL_SIGNED_EN defined: per-channel compare is two's-complement signed. Meaningful for DATA_W >= 2; for DATA_W=1 the value 1 counts as -1.
- POOL_SIGNED_EN undefined: unsigned compare; for DATA_W=1 this equals a bitwise OR.

Test Plan:
- Defaults, ch0 pixel = 1 only where row and col are both odd, all others 0, out_ready=1 -> 144 outputs; every output has ch0=1 and ch1..17=0; out_last only on the 144th; frame_err never pulses.
- CHANNELS=2, DATA_W=4, 4x4 frame; ch0 = row*4+col, ch1 = 15-(row*4+col) -> 4 outputs with ch0 = 5, 7, 13, 15 and ch1 = 15, 13, 7, 5; out_last on the 4th.
- Same config as the previous scenario, out_ready held low for 10 cycles after the first out_valid -> in_ready=0 and out_data stable throughout; the resulting sequence is identical with no loss or duplication.
- Default config, in_last asserted on beat 10 of a frame -> frame_err pulses one cycle after beat 10 and no output for the partial window; the following clean frame produces the correct 144 outputs.
- rst asserted after 30 accepted beats while an output is pending -> out_valid=0 immediately; the next full frame produces correct outputs starting at window (0,0).
- CHANNELS=1, DATA_W=4, 2x2 frame = {4'hF, 4'h1, 4'h0, 4'h2} -> output 4'h2 with POOL_SIGNED_EN defined, 4'hF without it.

Source files
------------

// File: rtl/pool_stream_if.sv
// Stream bundle for pool_stream: input pixel channel, output pooled channel and frame_err.
// A beat moves on a channel in the cycle where valid && ready; once valid is high the
// source holds data/last stable and keeps valid high until that cycle.
interface pool_stream_if #(
    parameter int CHANNELS = 18,
    parameter int DATA_W   = 1
);
    localparam int PW = CHANNELS * DATA_W;

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic          out_last;
    logic          frame_err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_err
    );
endinterface

// File: rtl/pool_stream.sv
// Streaming 2x2 / stride-2 max-pool over raster-ordered pixels with a half-width line buffer.
// Optional macro POOL_SIGNED_EN: per-channel compare becomes two's-complement signed.
module pool_stream #(
    parameter int CHANNELS = 18,
    parameter int DATA_W   = 1,
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24
) (
    input  logic          clk,
    input  logic          rst,
    pool_stream_if.slave  bus
);
    localparam int PW       = CHANNELS * DATA_W;
    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    function automatic logic [PW-1:0] pix_max(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0]     r;
        logic [DATA_W-1:0] ca;
        logic [DATA_W-1:0] cb;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ca = a[c*DATA_W +: DATA_W];
            cb = b[c*DATA_W +: DATA_W];
`ifdef POOL_SIGNED_EN
            r[c*DATA_W +: DATA_W] = ($signed(ca) > $signed(cb)) ? ca : cb;
`else
            r[c*DATA_W +: DATA_W] = (ca > cb) ? ca : cb;
`endif
        end
        return r;
    endfunction

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [PW-1:0]  hold_q, hold_d;
    logic           out_valid_q, out_valid_d;
    logic [PW-1:0]  out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic           frame_err_q, frame_err_d;

    logic [PW-1:0]  lbuf [LB_DEPTH];
    logic           lbuf_we;
    logic [PW-1:0]  lbuf_wdata;
    logic [LBW-1:0] lbuf_idx;
    logic [PW-1:0]  lbuf_rdata;

    logic in_ready;
    logic accept;
    logic last_col;
    logic last_row;
    logic final_pos;
    logic early_end;

    assign in_ready  = !rst && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign last_col  = (col_q == CW'(IMG_W - 1));
    assign last_row  = (row_q == RW'(IMG_H - 1));
    assign final_pos = last_col && last_row;
    assign early_end = accept && bus.in_last && !final_pos;

    assign lbuf_idx   = LBW'(col_q >> 1);
    assign lbuf_rdata = lbuf[lbuf_idx];

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;
        lbuf_we     = 1'b0;
        lbuf_wdata  = pix_max(hold_q, bus.in_data);

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            frame_err_d = (bus.in_last != final_pos);
            // Row parity picks top/bottom half of the window, column parity left/right.
            case ({row_q[0], col_q[0]})
                2'b00:   hold_d  = bus.in_data;
                2'b01:   lbuf_we = 1'b1;
                2'b10:   hold_d  = pix_max(lbuf_rdata, bus.in_data);
                default: begin
                    if (!early_end) begin
                        out_data_d  = pix_max(hold_q, bus.in_data);
                        out_valid_d = 1'b1;
                        out_last_d  = final_pos;
                    end
                end
            endcase

            // A premature in_last abandons the partial frame and resyncs to pixel (0,0).
            if (early_end) begin
                col_d = '0;
                row_d = '0;
            end else if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf[lbuf_idx] <= lbuf_wdata;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_pool_stream.sv
// Directed bench for pool_stream: three configurations behind one driver, a frame-level
// window model feeding an expected queue, and a per-cycle compare process.
module tb_pool_stream;
  localparam int W = 65;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel;
  int          cfg_ch, cfg_dw, cfg_w, cfg_h;
  logic        drv_valid = 1'b0;
  logic [63:0] drv_data = '0;
  logic        drv_last = 1'b0;
  logic        drv_out_ready = 1'b1;

  logic        mon_in_ready, mon_out_valid, mon_out_last, mon_frame_err;
  logic [63:0] mon_out_data;

  int compared = 0;
  int failed = 0;
  logic [W-1:0] exp_q[$];
  logic [63:0]  px[$];

  pool_stream_if #(.CHANNELS(18), .DATA_W(1)) if_a ();
  pool_stream_if #(.CHANNELS(2),  .DATA_W(4)) if_b ();
  pool_stream_if #(.CHANNELS(1),  .DATA_W(4)) if_c ();

  pool_stream #(.CHANNELS(18), .DATA_W(1), .IMG_W(24), .IMG_H(24)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pool_stream #(.CHANNELS(2),  .DATA_W(4), .IMG_W(4),  .IMG_H(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b));
  pool_stream #(.CHANNELS(1),  .DATA_W(4), .IMG_W(2),  .IMG_H(2))  dut_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.in_valid  = drv_valid && (sel == 0);
  assign if_a.in_data   = drv_data[17:0];
  assign if_a.in_last   = drv_last;
  assign if_a.out_ready = drv_out_ready;
  assign if_b.in_valid  = drv_valid && (sel == 1);
  assign if_b.in_data   = drv_data[7:0];
  assign if_b.in_last   = drv_last;
  assign if_b.out_ready = drv_out_ready;
  assign if_c.in_valid  = drv_valid && (sel == 2);
  assign if_c.in_data   = drv_data[3:0];
  assign if_c.in_last   = drv_last;
  assign if_c.out_ready = drv_out_ready;

  always_comb begin
    mon_in_ready  = 1'b0;
    mon_out_valid = 1'b0;
    mon_out_data  = '0;
    mon_out_last  = 1'b0;
    mon_frame_err = 1'b0;
    case (sel)
      0: begin
        mon_in_ready = if_a.in_ready; mon_out_valid = if_a.out_valid;
        mon_out_data = 64'(if_a.out_data); mon_out_last = if_a.out_last; mon_frame_err = if_a.frame_err;
      end
      1: begin
        mon_in_ready = if_b.in_ready; mon_out_valid = if_b.out_valid;
        mon_out_data = 64'(if_b.out_data); mon_out_last = if_b.out_last; mon_frame_err = if_b.frame_err;
      end
      default: begin
        mon_in_ready = if_c.in_ready; mon_out_valid = if_c.out_valid;
        mon_out_data = 64'(if_c.out_data); mon_out_last = if_c.out_last; mon_frame_err = if_c.frame_err;
      end
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int s);
    sel = s;
    case (s)
      0:       begin cfg_ch = 18; cfg_dw = 1; cfg_w = 24; cfg_h = 24; end
      1:       begin cfg_ch = 2;  cfg_dw = 4; cfg_w = 4;  cfg_h = 4;  end
      default: begin cfg_ch = 1;  cfg_dw = 4; cfg_w = 2;  cfg_h = 2;  end
    endcase
  endtask

  // ---------------- model: per-window channel maxima over the stored frame ----------------
  function automatic int chv(input logic [63:0] p, input int c);
    int v;
    v = int'((p >> (c * cfg_dw)) & ((64'd1 << cfg_dw) - 64'd1));
`ifdef POOL_SIGNED_EN
    if (v >= (1 << (cfg_dw - 1))) v = v - (1 << cfg_dw);
`endif
    return v;
  endfunction

  task automatic model_frame(input int n_beats, input bit trunc);
    int tl, br, m;
    logic [63:0] d;
    logic        last;
    for (int wr = 0; wr < cfg_h / 2; wr++) begin
      for (int wc = 0; wc < cfg_w / 2; wc++) begin
        tl = 2 * wr * cfg_w + 2 * wc;
        br = tl + cfg_w + 1;
        if (br < n_beats && !(trunc && br == n_beats - 1)) begin
          d = '0;
          for (int c = 0; c < cfg_ch; c++) begin
            m = chv(px[tl], c);
            if (chv(px[tl + 1], c) > m)     m = chv(px[tl + 1], c);
            if (chv(px[tl + cfg_w], c) > m) m = chv(px[tl + cfg_w], c);
            if (chv(px[br], c) > m)         m = chv(px[br], c);
            d = d | ((64'(m) & ((64'd1 << cfg_dw) - 64'd1)) << (c * cfg_dw));
          end
          last = (wr == cfg_h / 2 - 1) && (wc == cfg_w / 2 - 1);
          exp_q.push_back({last, d});
        end
      end
    end
  endtask

  task automatic fill_odd_ch0();
    px.delete();
    for (int i = 0; i < cfg_w * cfg_h; i++)
      px.push_back(((i / cfg_w) % 2 == 1 && (i % cfg_w) % 2 == 1) ? 64'd1 : 64'd0);
  endtask

  task automatic fill_mix(input int seed);
    int r, c;
    px.delete();
    for (int i = 0; i < cfg_w * cfg_h; i++) begin
      r = i / cfg_w;
      c = i % cfg_w;
      px.push_back(64'((r * 131 + c * 17 + r * c + seed * 7) * 32'h9E3779B1) &
                   ((64'd1 << (cfg_ch * cfg_dw)) - 64'd1));
    end
  endtask

  // ---------------- driver: tasks start and end on a falling edge ----------------
  task automatic drive_beat(input logic [63:0] d, input bit last, input bit exp_err);
    int n;
    drv_valid = 1'b1;
    drv_data  = d;
    drv_last  = last;
    n = 0;
    while (!mon_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      failed++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      drv_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    check("frame_err", 65'(mon_frame_err), 65'(exp_err));
  endtask

  task automatic drive_frame(input int n, input bit with_last);
    bit last;
    for (int i = 0; i < n; i++) begin
      last = with_last && (i == n - 1);
      drive_beat(px[i], last, ((i == cfg_w * cfg_h - 1) != last));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 65'(exp_q.size()), 65'd0);
  endtask

  // ---------------- compare process ----------------
  bit          stall_prev = 1'b0;
  logic [63:0] stall_data;
  logic        stall_last;

  always @(negedge clk) begin
    if (rst) begin
      check("valid_in_reset", 65'(mon_out_valid), 65'd0);
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 65'(mon_out_valid), 65'd1);
        check("stall_hold", {mon_out_last, mon_out_data}, {stall_last, stall_data});
      end
      if (mon_out_valid && !drv_out_ready) begin
        check("stall_in_ready", 65'(mon_in_ready), 65'd0);
        stall_prev <= 1'b1;
        stall_data <= mon_out_data;
        stall_last <= mon_out_last;
      end else begin
        stall_prev <= 1'b0;
      end
      if (mon_out_valid && drv_out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected_out: got %h expected none", {mon_out_last, mon_out_data});
        end else begin
          check("out_beat", {mon_out_last, mon_out_data}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    set_cfg(0);
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      set_cfg(s);
      #1;
      check("rst_in_ready", 65'(mon_in_ready), 65'd0);
      check("rst_out_valid", 65'(mon_out_valid), 65'd0);
      check("rst_out_data", 65'(mon_out_data), 65'd0);
      check("rst_out_last", 65'(mon_out_last), 65'd0);
      check("rst_frame_err", 65'(mon_frame_err), 65'd0);
    end
    set_cfg(0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Sparse ch0 pattern: every window holds exactly one 1 in ch0.
    fill_odd_ch0();
    model_frame(576, 1'b0);
    check("pin_a_count", 65'(exp_q.size()), 65'd144);
    check("pin_a_first", exp_q[0], {1'b0, 64'h1});
    check("pin_a_last", exp_q[143], {1'b1, 64'h1});
    drive_frame(576, 1'b1);
    drain();

    // Early in_last on the 10th beat, then a clean frame.
    fill_mix(1);
    model_frame(10, 1'b1);
    check("pin_trunc_none", 65'(exp_q.size()), 65'd0);
    drive_frame(10, 1'b1);
    fill_mix(5);
    model_frame(576, 1'b0);
    drive_frame(576, 1'b1);
    drain();

    // Reset after 30 accepted beats with the third window's output pending.
    fill_mix(2);
    model_frame(30, 1'b0);
    drive_frame(29, 1'b0);
    drv_valid = 1'b1;
    drv_data  = px[29];
    drv_last  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    drv_valid = 1'b0;
    #1;
    check("rst_mid_valid", 65'(mon_out_valid), 65'd0);
    check("rst_mid_pending", 65'(exp_q.size()), 65'd1);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    fill_mix(3);
    model_frame(576, 1'b0);
    drive_frame(576, 1'b1);
    drain();

    // 4x4, 2 channels x 4 bits, with a backpressure stall.
    @(posedge clk);
    #1 set_cfg(1);
    @(negedge clk);
    px.delete();
    for (int p = 0; p < 16; p++) px.push_back(64'(((15 - p) << 4) | p));
    model_frame(16, 1'b0);
    check("pin_b0", exp_q[0], {1'b0, 64'hF5});
    check("pin_b1", exp_q[1], {1'b0, 64'hD7});
    check("pin_b2", exp_q[2], {1'b0, 64'h7D});
    check("pin_b3", exp_q[3], {1'b1, 64'h5F});
    fork
      drive_frame(16, 1'b1);
      begin
        for (int i = 0; i < 200 && !mon_out_valid; i++) @(negedge clk);
        @(posedge clk);
        #1 drv_out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 drv_out_ready = 1'b1;
      end
    join
    drain();

    // 2x2 single 4-bit channel: signed vs unsigned compare.
    @(posedge clk);
    #1 set_cfg(2);
    @(negedge clk);
    px.delete();
    px.push_back(64'hF); px.push_back(64'h1); px.push_back(64'h0); px.push_back(64'h2);
    model_frame(4, 1'b0);
`ifdef POOL_SIGNED_EN
    check("pin_c", exp_q[0], {1'b1, 64'h2});
`else
    check("pin_c", exp_q[0], {1'b1, 64'hF});
`endif
    drive_frame(4, 1'b1);
    drain();
    // Final position without in_last still pools the window and flags the frame.
    model_frame(4, 1'b0);
    drive_frame(4, 1'b0);
    drain();
    model_frame(4, 1'b0);
    drive_frame(4, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
